ga23_sdr_arbiter: RTL and testbench
===================================

Name: ga23_sdr_arbiter

Overview:
- Shares one SDRAM tile-row read port between the GA23 background layers; each layer issues single-cycle `sdr_req` pulses with a 22-bit address.
- The block latches pending requests, grants them round-robin, and issues one read at a time to the SDRAM controller.
- It routes the 32-bit row data back to the owning layer with a one-cycle ready pulse.
- It sits between the layer instances and the SDRAM channel assigned to the tile ROM.

Parameters:
- NUM_REQ, 3, number of requesting layers.
- ADDR_W, 22, request/SDRAM word address width.
- DATA_W, 32, row data width.
- TIMEOUT, 64, cycles to wait for `mem_rdy` before aborting a grant; 0 disables the timeout.

Ports:
- clk  in  1  system clock; everything is on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  per-layer single-cycle request pulse.
- req_addr  in  NUM_REQ*ADDR_W  per-layer address; slice i is valid when req[i]=1.
- rdy  out  NUM_REQ  per-layer single-cycle completion pulse.
- data  out  NUM_REQ*DATA_W  per-layer returned row, held until that layer's next completion.
- mem_addr  out  ADDR_W  address to the SDRAM controller.
- mem_req  out  1  single-cycle read request pulse.
- mem_rdy  in  1  SDRAM data-valid pulse.
- mem_data  in  DATA_W  SDRAM read data, valid when mem_rdy=1.
- timeout_cnt  out  8  saturating count of aborted grants.

Behaviour:
- Synchronous, active-low reset: all outputs, pending flags, latched addresses and the data registers go to 0. State=IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first). Any reset mid-operation drops all pending and in-flight work; a late mem_rdy after reset is ignored.
- Request capture, every cycle independent of state: req[i]=1 sets pend[i] and loads addr_q[i]<=req_addr slice i.
  - A repeat request while pend[i]=1 overwrites addr_q[i] (latest wins); there is no second entry.
- State IDLE: if any pend bit is set, choose the first set bit scanning last_grant+1, +2, ... modulo NUM_REQ. Then:
  - gnt<=i, last_grant<=i, mem_addr<=addr_q[i], mem_req<=1 (for exactly one cycle), tmr<=0, state<=WAIT.
  - The grant decision uses pend values from before the current edge: a req arriving in the same cycle is not granted until the next cycle.
- State WAIT: mem_req=0; tmr increments each cycle.
  - mem_rdy=1 (may coincide with the cycle mem_req is high): data slice gnt<=mem_data, rdy[gnt]<=1 for one cycle, pend[gnt] cleared, state<=IDLE.
  - TIMEOUT!=0 and tmr==TIMEOUT-1 without mem_rdy: rdy[gnt] still pulses (the layer must not stall), data slice unchanged, pend[gnt] cleared, timeout_cnt increments (saturating at 255), state<=IDLE.
- Simultaneous completion and req for the same i: the completion applies to the old address; pend[i] remains set with the new address.
- mem_rdy is ignored in IDLE.
- Latency with an idle arbiter:
  - req at edge k → pend at k, mem_req high after edge k+1.
  - mem_rdy sampled at edge m → rdy/data valid after edge m.
  - The back-to-back grant gap is one IDLE cycle.
- Arbitration is fair: with all requesters continuously pending, grants cycle 0,1,2,0,...
- Width rules: address and data pass through unmodified. tmr is wide enough to hold TIMEOUT-1.
- rdy is one-hot or zero at all times.

Test Plan:
- Reset, then req[1] with addr 0x12340 → mem_req pulses with mem_addr=0x12340 two cycles later; mem_rdy three cycles after that with 0xDEADBEEF → rdy=3'b010 for one cycle, data[1]=0xDEADBEEF held.
- req on all three layers in the same cycle, mem_rdy one cycle after each mem_req → grant order 0,1,2; mem_req pulses spaced 3 cycles apart; each rdy carries its own data.
- req[0] addr A, then req[0] addr B before the grant → a single mem_req with B, a single rdy[0].
- req[2] in the exact cycle mem_rdy completes layer 2's earlier read → rdy[2] carries the old data; a second grant for layer 2 follows with the new address.
- TIMEOUT=64 with mem_rdy never asserted → rdy[gnt] pulses 64 cycles after mem_req, data unchanged, timeout_cnt=1; a subsequent request is served normally.
- reset_n low while in WAIT, then mem_rdy arrives → no rdy pulse, all outputs 0, and the next request is granted to requester 0 first.

Source files
------------

// File: rtl/ga23_sdr_arbiter.sv
// GA23 background-layer SDRAM row arbiter.
// Requests are latched per layer and granted round-robin. One read is in flight at a
// time. Returned rows go back to the owning layer with a one-cycle ready pulse.
// A grant that gets no mem_rdy within TIMEOUT cycles is aborted so the layer never stalls.
module ga23_sdr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 22,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        rdy,
  output logic [NUM_REQ*DATA_W-1:0] data,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_req,
  input  logic                      mem_rdy,
  input  logic [DATA_W-1:0]         mem_data,
  output logic [7:0]                timeout_cnt
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Wide enough to hold TIMEOUT-1.
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  pend_q;
  logic [ADDR_W-1:0]   addr_q [NUM_REQ];
  logic [DATA_W-1:0]   data_q [NUM_REQ];
  logic [IdxW-1:0]     gnt_q;
  logic [IdxW-1:0]     last_q;
  logic [TmrW-1:0]     tmr_q;
  logic [NUM_REQ-1:0]  rdy_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_req_q;
  logic [7:0]          to_cnt_q;

  logic [ADDR_W-1:0]   req_addr_a [NUM_REQ];
  logic                pick_vld;
  logic [IdxW-1:0]     pick_idx;
  logic                tmr_expired;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign req_addr_a[gi]              = req_addr[gi*ADDR_W +: ADDR_W];
    assign data[gi*DATA_W +: DATA_W]   = data_q[gi];
  end

  // Round-robin pick: first pending requester after the last one granted.
  always_comb begin : pick_comb
    int unsigned     idx_full;
    logic [IdxW-1:0] idx;
    idx_full = 0;
    idx      = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx_full = (32'(last_q) + k) % NUM_REQ;
      idx      = IdxW'(idx_full);
      if (!pick_vld && pend_q[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // Abort condition for the in-flight grant; never fires when TIMEOUT is 0.
  always_comb begin
    tmr_expired = 1'b0;
    if (TIMEOUT != 0) begin
      tmr_expired = (tmr_q == TmrW'(TIMEOUT - 1));
    end
  end

  // Arbiter FSM, request capture and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pend_q     <= '0;
      gnt_q      <= '0;
      last_q     <= IdxW'(NUM_REQ - 1);
      tmr_q      <= '0;
      rdy_q      <= '0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      to_cnt_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rdy_q     <= '0;
      mem_req_q <= 1'b0;

      case (state_q)
        StIdle: begin
          if (pick_vld) begin
            gnt_q      <= pick_idx;
            last_q     <= pick_idx;
            mem_addr_q <= addr_q[pick_idx];
            mem_req_q  <= 1'b1;
            tmr_q      <= '0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          tmr_q <= tmr_q + TmrW'(1);
          if (mem_rdy) begin
            data_q[gnt_q] <= mem_data;
            rdy_q[gnt_q]  <= 1'b1;
            pend_q[gnt_q] <= 1'b0;
            state_q       <= StIdle;
          end else if (tmr_expired) begin
            // Layer still gets its pulse; its data register is left untouched.
            rdy_q[gnt_q]  <= 1'b1;
            pend_q[gnt_q] <= 1'b0;
            if (to_cnt_q != 8'hFF) begin
              to_cnt_q <= to_cnt_q + 8'd1;
            end
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Capture comes last so a request landing with its own completion stays pending.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i]) begin
          pend_q[i] <= 1'b1;
          addr_q[i] <= req_addr_a[i];
        end
      end
    end
  end

  assign rdy         = rdy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_req     = mem_req_q;
  assign timeout_cnt = to_cnt_q;

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Self-checking bench for ga23_sdr_arbiter: table-driven single requests plus
// hand-written multi-cycle sequences; completions are checked through a scoreboard.
module tb_ga23_sdr_arbiter;

  localparam int NR = 3;
  localparam int AW = 22;
  localparam int DW = 32;
  localparam int TO = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NR-1:0]    req;
  logic [NR*AW-1:0] req_addr;
  logic [NR-1:0]    rdy;
  logic [NR*DW-1:0] data;
  logic [AW-1:0]    mem_addr;
  logic             mem_req;
  logic             mem_rdy;
  logic [DW-1:0]    mem_data;
  logic [7:0]       timeout_cnt;

  ga23_sdr_arbiter #(
    .NUM_REQ(NR),
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_addr   (req_addr),
    .rdy        (rdy),
    .data       (data),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_rdy    (mem_rdy),
    .mem_data   (mem_data),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int            layer;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int            layer;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    int            delay;
  } vec_t;
  vec_t vecs[4];

  logic [DW-1:0] model_data [NR];
  logic          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Every rdy pulse must match the oldest expected completion.
  always @(negedge clk) begin
    sb_t e;
    if (mon_en && rdy !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got rdy=%b expected 000", rdy);
      end else begin
        e = sb.pop_front();
        chk("rdy_onehot", 64'(rdy), 64'(3'b001 << e.layer));
        chk("rdy_data", 64'(data[e.layer*DW +: DW]), 64'(e.data));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_req(input int l, input logic [AW-1:0] a);
    req[l] = 1'b1;
    req_addr[l*AW +: AW] = a;
    step();
    req = '0;
  endtask

  task automatic wait_grant(input string name, input logic [AW-1:0] a,
                            output int lat, output int unsigned t);
    lat = 0;
    while (mem_req !== 1'b1 && lat < 100) begin
      step();
      lat++;
    end
    if (mem_req !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: got mem_req=0 for 100 cycles expected 1", name);
    end else begin
      chk({name, "_addr"}, 64'(mem_addr), 64'(a));
    end
    t = cyc;
  endtask

  task automatic complete(input int l, input logic [DW-1:0] d, input int delay);
    repeat (delay) step();
    mem_rdy  = 1'b1;
    mem_data = d;
    sb.push_back('{l, d});
    model_data[l] = d;
    step();
    mem_rdy  = 1'b0;
    mem_data = $urandom();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    int          n;
    int unsigned t0, t1, t2;

    vecs[0] = '{0, 22'h000001, 32'h11111111, 0};
    vecs[1] = '{1, 22'h2AAAAA, 32'h00000000, 4};
    vecs[2] = '{0, 22'h155555, 32'hA5A5A5A5, 2};
    vecs[3] = '{2, 22'h3FFFFF, 32'hFFFFFFFF, 1};
    for (int i = 0; i < NR; i++) model_data[i] = '0;

    req = '0; req_addr = '0; mem_rdy = 1'b0; mem_data = '0; reset_n = 1'b0;
    repeat (3) step();
    chk("rst_rdy", 64'(rdy), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0);
    chk("rst_timeout_cnt", 64'(timeout_cnt), 0);
    for (int i = 0; i < NR; i++) chk("rst_data", 64'(data[i*DW +: DW]), 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    step();

    // Basic latency and pulse shape.
    req[1] = 1'b1;
    req_addr[AW +: AW] = 22'h12340;
    step();
    req = '0;
    chk("t1_no_early_grant", 64'(mem_req), 0);
    step();
    chk("t1_mem_req", 64'(mem_req), 1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h12340);
    step();
    chk("t1_pulse_width", 64'(mem_req), 0);
    complete(1, 32'hDEADBEEF, 2);
    step(); step();
    chk("t1_data_held", 64'(data[DW +: DW]), 64'hDEADBEEF);

    // mem_rdy while idle must be ignored.
    mem_rdy = 1'b1; mem_data = 32'h0BADF00D;
    step();
    mem_rdy = 1'b0;
    step();
    chk("idle_mem_rdy_rdy", 64'(rdy), 0);
    chk("idle_mem_rdy_data", 64'(data[DW +: DW]), 64'hDEADBEEF);

    for (int i = 0; i < 4; i++) begin
      send_req(vecs[i].layer, vecs[i].addr);
      wait_grant("vec_grant", vecs[i].addr, lat, t0);
      chk("vec_latency", 64'(lat), 1);
      complete(vecs[i].layer, vecs[i].rdata, vecs[i].delay);
      step();
    end

    // All three at once: order 0,1,2, grants three cycles apart.
    req = 3'b111;
    req_addr = {22'h222222, 22'h111111, 22'h000AAA};
    step();
    req = '0;
    wait_grant("t2_g0", 22'h000AAA, lat, t0);
    complete(0, 32'hC0C0C0C0, 1);
    wait_grant("t2_g1", 22'h111111, lat, t1);
    complete(1, 32'hC1C1C1C1, 1);
    wait_grant("t2_g2", 22'h222222, lat, t2);
    complete(2, 32'hC2C2C2C2, 1);
    chk("t2_gap01", 64'(t1 - t0), 3);
    chk("t2_gap12", 64'(t2 - t1), 3);
    step();

    // Repeat request before grant: latest address wins, single grant.
    send_req(1, 22'h0F0F0F);
    req[0] = 1'b1; req_addr[0 +: AW] = 22'h00A000;
    step();
    chk("t3_busy_grant", 64'(mem_req), 1);
    chk("t3_busy_addr", 64'(mem_addr), 64'h0F0F0F);
    req[0] = 1'b1; req_addr[0 +: AW] = 22'h00B000;
    step();
    req = '0;
    complete(1, 32'h12121212, 2);
    wait_grant("t3_g0", 22'h00B000, lat, t0);
    complete(0, 32'hB0B0B0B0, 0);
    n = 0;
    repeat (10) begin
      step();
      if (mem_req === 1'b1) n++;
    end
    chk("t3_single_grant", 64'(n), 0);

    // Request coincides with its own completion: old data returned, regrant with new addr.
    send_req(2, 22'h020001);
    wait_grant("t4_g_old", 22'h020001, lat, t0);
    step();
    mem_rdy = 1'b1; mem_data = 32'h0D0D0D0D;
    sb.push_back('{2, 32'h0D0D0D0D});
    model_data[2] = 32'h0D0D0D0D;
    req[2] = 1'b1; req_addr[2*AW +: AW] = 22'h020002;
    step();
    mem_rdy = 1'b0; req = '0;
    wait_grant("t4_g_new", 22'h020002, lat, t0);
    chk("t4_regrant_lat", 64'(lat), 1);
    complete(2, 32'h0E0E0E0E, 1);
    step();

    // Timeout: no mem_rdy.
    send_req(0, 22'h3C0000);
    wait_grant("t5_g", 22'h3C0000, lat, t0);
    sb.push_back('{0, model_data[0]});
    n = 0;
    while (rdy === '0 && n < 100) begin
      step();
      n++;
    end
    chk("t5_timeout_delay", 64'(cyc - t0), 64'(TO));
    chk("t5_data_held", 64'(data[0 +: DW]), 64'(model_data[0]));
    chk("t5_timeout_cnt", 64'(timeout_cnt), 1);
    step();
    send_req(1, 22'h001234);
    wait_grant("t5_after", 22'h001234, lat, t0);
    complete(1, 32'h5A5A5A5A, 0);
    step();

    // Reset while waiting; late mem_rdy ignored; requester 0 wins first afterwards.
    send_req(1, 22'h00FFFF);
    wait_grant("t6_g", 22'h00FFFF, lat, t0);
    step();
    reset_n = 1'b0;
    step();
    mem_rdy = 1'b1; mem_data = 32'h77777777;
    step();
    reset_n = 1'b1;
    step();
    mem_rdy = 1'b0;
    step();
    for (int i = 0; i < NR; i++) model_data[i] = '0;
    chk("t6_rdy", 64'(rdy), 0);
    chk("t6_mem_req", 64'(mem_req), 0);
    chk("t6_mem_addr", 64'(mem_addr), 0);
    chk("t6_timeout_cnt", 64'(timeout_cnt), 0);
    for (int i = 0; i < NR; i++) chk("t6_data", 64'(data[i*DW +: DW]), 0);
    req = 3'b101;
    req_addr = {22'h2B0000, 22'h000000, 22'h0A0000};
    step();
    req = '0;
    wait_grant("t6_first", 22'h0A0000, lat, t0);
    complete(0, 32'hF0F0F0F0, 1);
    wait_grant("t6_second", 22'h2B0000, lat, t0);
    complete(2, 32'hF2F2F2F2, 1);
    n = 0;
    repeat (10) begin
      step();
      if (mem_req === 1'b1) n++;
    end
    chk("t6_dropped_pend", 64'(n), 0);

    chk("sb_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
